barrel_shifter_pipe: RTL
========================

Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined barrel shifter, successor to the 8-bit combinational rotate-right shifter. It supports WIDTH-bit data and four shift modes: rotate right, rotate left, logical right and arithmetic right. It has one register stage per shift level and valid/ready flow control on both sides. It sits in datapaths that need one shift result per clock at high frequency, with back-pressure from the consumer.

Parameters:
WIDTH, 8, data width in bits; must be a power of two, >= 2.
AMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
STAGES, AMT_W, pipeline depth; fixed, one stage per amount bit.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input this cycle
in_data  in  WIDTH  operand
in_amt  in  AMT_W  shift amount, 0..WIDTH-1
in_op  in  2  mode: 00 ROR, 01 ROL, 10 SRL, 11 SRA
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  shifted result
out_sticky  out  1  present only with SHIFT_STICKY_EN (see below)

Behaviour:
- Reset is asynchronous on rst_n low and released synchronously to clk.
  - During reset, all stage valid bits clear; data, amt and op registers clear to 0.
  - Outputs during reset: out_valid=0, out_data=0, out_sticky=0, in_ready=1.
- Stage k (k=0..STAGES-1) handles amount bit AMT_W-1-k, i.e. shift distance WIDTH>>(k+1). Most significant amount bit is applied first.
- Each stage register holds data, the remaining amount bits, op and valid. op and amt travel with the data.
- Per-stage shift by distance d when the amount bit is 1; pass-through when it is 0:
  - ROR: bits rotate toward bit 0; bit i takes bit (i+d) mod WIDTH.
  - ROL: bit i takes bit (i-d) mod WIDTH.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the original operand MSB. The sign bit is captured at input and carried down the pipe.
- Latency: STAGES cycles from in_valid&&in_ready to out_valid, with no stalls.
- Throughput: one beat per cycle while out_ready=1.
- Flow control per stage:
  - stage_ready[k] = !valid[k] || stage_ready[k+1]; stage_ready[STAGES] = out_ready.
  - in_ready = stage_ready[0]. It is combinational from out_ready through the valid chain.
  - A stage loads when its upstream is valid and stage_ready[k] is 1.
  - A stage clears valid when its downstream accepts and nothing new arrives.
  - A stalled stage holds its contents unchanged.
- out_valid and out_data hold stable while out_valid=1 and out_ready=0.
- Simultaneous accept at input and output in the same cycle with a full pipe: both transfers occur; occupancy is unchanged.
- in_amt=0: data passes unchanged in every mode; latency is still STAGES.
- Reset asserted mid-operation: all in-flight beats are discarded. There is no partial output.
- WIDTH=2 degenerates to a single stage. Behaviour is otherwise identical.

Optional Feature:
SHIFT_STICKY_EN
- Defined:
  - out_sticky port exists.
  - For SRL/SRA it equals the OR of all bits shifted out across all stages. Each stage ORs in the bits it discards, and the result travels with the data.
  - For ROR/ROL it is 0.
  - Reset value 0. Holds with out_data under stall.
- Undefined: out_sticky port and its pipeline registers are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, ROR 0x96 amt 3 -> out_data 0xD2 three cycles after accept; sticky=0.
- ROL 0x96 amt 3 -> 0xB4; SRL 0x96 amt 3 -> 0x12, sticky=1; SRA 0x96 amt 3 -> 0xF2, sticky=1; SRL 0x90 amt 3 -> 0x12, sticky=0.
- Streaming: 256 back-to-back random beats with out_ready=1 -> one result per cycle, in order, matching the golden model for all ops and amts 0..7.
- Back-pressure: hold out_ready=0 and drive in_valid=1 continuously.
  - Expect exactly 3 beats accepted, then in_ready=0.
  - out_data stays stable.
  - After out_ready=1, results drain in order with no loss or duplication.
- Random out_ready toggling (50%) over 1000 beats -> scoreboard match; out_data never changes while out_valid&&!out_ready.
- Assert rst_n low with 2 beats in flight -> out_valid=0 and out_data=0 immediately (asynchronously); no stale result after release.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter (ROR/ROL/SRL/SRA), one register stage per amount bit.
// Optional SHIFT_STICKY_EN adds out_sticky: OR of all bits shifted out by SRL/SRA.
`timescale 1ns/1ps

module barrel_shifter_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef SHIFT_STICKY_EN
    ,
    output logic                     out_sticky
`endif
);

    localparam int AMT_W  = $clog2(WIDTH);
    localparam int STAGES = AMT_W;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // Tap k is the input of stage k; tap STAGES is the pipeline output.
    logic [WIDTH-1:0] tap_data  [STAGES+1];
    logic [AMT_W-1:0] tap_amt   [STAGES+1];
    logic [1:0]       tap_op    [STAGES+1];
    logic             tap_sign  [STAGES+1];
    logic             tap_valid [STAGES+1];
    logic             ready_chain [STAGES+1];
`ifdef SHIFT_STICKY_EN
    logic             tap_sticky [STAGES+1];
`endif

    assign tap_data[0]  = in_data;
    assign tap_amt[0]   = in_amt;
    assign tap_op[0]    = in_op;
    assign tap_sign[0]  = in_data[WIDTH-1];
    assign tap_valid[0] = in_valid;
`ifdef SHIFT_STICKY_EN
    assign tap_sticky[0] = 1'b0;
`endif

    // Ready ripples back from the consumer through every stage's valid bit.
    always_comb begin
        for (int k = 0; k <= STAGES; k++) begin
            ready_chain[k] = 1'b0;
        end
        ready_chain[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_chain[k] = !tap_valid[k+1] || ready_chain[k+1];
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            localparam int DIST = WIDTH >> (gi + 1);

            logic [WIDTH-1:0] data_reg;
            logic [AMT_W-1:0] amt_reg;
            logic [1:0]       op_reg;
            logic             sign_reg;
            logic             valid_reg;
            logic [WIDTH-1:0] shifted;
            logic             shift_bit;

            assign shift_bit = tap_amt[gi][AMT_W-1-gi];

            always_comb begin
                shifted = tap_data[gi];
                if (shift_bit) begin
                    case (tap_op[gi])
                        OP_ROR:  shifted = {tap_data[gi][DIST-1:0], tap_data[gi][WIDTH-1:DIST]};
                        OP_ROL:  shifted = {tap_data[gi][WIDTH-DIST-1:0], tap_data[gi][WIDTH-1:WIDTH-DIST]};
                        OP_SRL:  shifted = {{DIST{1'b0}}, tap_data[gi][WIDTH-1:DIST]};
                        OP_SRA:  shifted = {{DIST{tap_sign[gi]}}, tap_data[gi][WIDTH-1:DIST]};
                        default: shifted = tap_data[gi];
                    endcase
                end
            end

`ifdef SHIFT_STICKY_EN
            logic sticky_reg;
            logic sticky_next;

            // Only the logical/arithmetic shifts discard bits; rotates keep them all.
            assign sticky_next = tap_sticky[gi]
                               | (shift_bit && tap_op[gi][1] && (|tap_data[gi][DIST-1:0]));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sticky_reg <= 1'b0;
                end else if (ready_chain[gi] && tap_valid[gi]) begin
                    sticky_reg <= sticky_next;
                end
            end

            assign tap_sticky[gi+1] = sticky_reg;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg  <= '0;
                    amt_reg   <= '0;
                    op_reg    <= '0;
                    sign_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end else if (ready_chain[gi]) begin
                    valid_reg <= tap_valid[gi];
                    if (tap_valid[gi]) begin
                        data_reg <= shifted;
                        amt_reg  <= tap_amt[gi];
                        op_reg   <= tap_op[gi];
                        sign_reg <= tap_sign[gi];
                    end
                end
            end

            assign tap_data[gi+1]  = data_reg;
            assign tap_amt[gi+1]   = amt_reg;
            assign tap_op[gi+1]    = op_reg;
            assign tap_sign[gi+1]  = sign_reg;
            assign tap_valid[gi+1] = valid_reg;
        end
    endgenerate

    assign in_ready  = ready_chain[0];
    assign out_valid = tap_valid[STAGES];
    assign out_data  = tap_data[STAGES];
`ifdef SHIFT_STICKY_EN
    assign out_sticky = tap_sticky[STAGES];
`endif

endmodule
